// File: rtl/uart_pkg.sv
// Shared constants for the 6809 <-> FT2232 UART: status/control bit positions
// and the common RX/TX serial state encoding.
package uart_pkg;

  localparam int ST_RXNE   = 0;
  localparam int ST_TXNF   = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_FRM    = 3;
  localparam int ST_TXIDLE = 4;
  localparam int ST_PAR    = 5;
  localparam int ST_TXOVF  = 6;
  localparam int ST_IRQ    = 7;

  localparam int CT_RXIE  = 0;
  localparam int CT_TXIE  = 1;
  localparam int CT_ODD   = 2;
  localparam int CT_FLUSH = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head and synchronous flush.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_interface.sv
// 6809-bus UART with RX/TX FIFOs, error flags and maskable IRQ.
// Define UART_PARITY_EN for 8-bit + parity framing (even, or odd via control[2]).
module uart_fifo_interface
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 770,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_RW,
  input  logic              i_uart_data_ce,
  input  logic              i_uart_control_ce,
  input  logic [DATA_W-1:0] i_uart_rxdata,
  input  logic [DATA_W-1:0] i_control,
  input  logic              i_UART_TX,
  output logic              o_UART_RX,
  output logic [DATA_W-1:0] o_uart_txdata,
  output logic [DATA_W-1:0] o_uart_status,
  output logic [DATA_W-1:0] o_control,
  output logic              o_IRQ
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  // Bus strobes: a CE level is turned into a one-clock action on its rising
  // edge; i_RW and write data are sampled in that same clock.
  logic data_ce_q, ctrl_ce_q, flush_q, clr_q;
  logic tx_wr, rx_rd, ctrl_wr, stat_rd;
  logic [DATA_W-1:0] ctrl_q;

  assign tx_wr   = i_uart_data_ce    & ~data_ce_q & ~i_RW;
  assign rx_rd   = i_uart_data_ce    & ~data_ce_q &  i_RW;
  assign ctrl_wr = i_uart_control_ce & ~ctrl_ce_q & ~i_RW;
  assign stat_rd = i_uart_control_ce & ~ctrl_ce_q &  i_RW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_ce_q <= 1'b0;
      ctrl_ce_q <= 1'b0;
      flush_q   <= 1'b0;
      clr_q     <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      data_ce_q <= i_uart_data_ce;
      ctrl_ce_q <= i_uart_control_ce;
      flush_q   <= ctrl_wr & i_control[CT_FLUSH];
      clr_q     <= stat_rd;
      if (ctrl_wr) begin
        ctrl_q           <= i_control;
        ctrl_q[CT_FLUSH] <= 1'b0;
      end
    end
  end

  logic              rx_push_q, rx_full, rx_empty, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] rx_head, tx_head, rx_shift, hold_q;
  logic [FW:0]       rx_count, tx_count;

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clk(clk), .rst(reset), .flush(flush_q), .push(rx_push_q), .pop(rx_rd),
    .din(rx_shift), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk(clk), .rst(reset), .flush(flush_q), .push(tx_wr), .pop(tx_pop),
    .din(i_uart_rxdata), .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // Keep showing the last head once the RX FIFO drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          hold_q <= '0;
    else if (!rx_empty) hold_q <= rx_head;
  end
  assign o_uart_txdata = rx_empty ? hold_q : rx_head;

  // Receiver
  logic              rx_s1, rx_s2, rx_s3, ovr_set, frm_set, par_set;
  uart_state_t       rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [BW-1:0]     rx_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_push_q <= 1'b0;
      ovr_set   <= 1'b0;
      frm_set   <= 1'b0;
      par_set   <= 1'b0;
    end else begin
      rx_s1     <= i_UART_TX;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      rx_push_q <= 1'b0;
      ovr_set   <= 1'b0;
      frm_set   <= 1'b0;
      par_set   <= 1'b0;
      rx_cnt    <= rx_cnt + 1'b1;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (rx_s3 && !rx_s2) rx_state <= S_START;
        end
        S_START: if (rx_cnt == HALF_END) begin
          rx_cnt   <= '0;
          rx_idx   <= '0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_idx   <= rx_idx + 1'b1;
          rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
          if (rx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state <= S_PARITY;
`else
            rx_state <= S_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          par_set  <= rx_s2 ^ (^rx_shift) ^ ctrl_q[CT_ODD];
          rx_state <= S_STOP;
        end
`endif
        S_STOP: if (rx_cnt == BIT_END) begin
          rx_state <= S_IDLE;
          if (!rx_s2)       frm_set   <= 1'b1;
          else if (rx_full) ovr_set   <= 1'b1;
          else              rx_push_q <= 1'b1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Transmitter: the next byte is fetched at the end of STOP so frames abut.
  uart_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [BW-1:0] tx_idx;
  logic [DATA_W-1:0] tx_shift;
`ifdef UART_PARITY_EN
  logic          tx_par;
`endif

  always_comb begin
    tx_pop = 1'b0;
    if (!tx_empty && !flush_q) begin
      if (tx_state == S_IDLE) tx_pop = 1'b1;
      else if (tx_state == S_STOP && tx_cnt == BIT_END) tx_pop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      o_UART_RX <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
      if (tx_pop) begin
        tx_state  <= S_START;
        tx_cnt    <= '0;
        tx_shift  <= tx_head;
        o_UART_RX <= 1'b0;
`ifdef UART_PARITY_EN
        tx_par    <= (^tx_head) ^ ctrl_q[CT_ODD];
`endif
      end else begin
        case (tx_state)
          S_IDLE: tx_cnt <= '0;
          S_START: if (tx_cnt == BIT_END) begin
            tx_cnt    <= '0;
            tx_idx    <= '0;
            o_UART_RX <= tx_shift[0];
            tx_shift  <= tx_shift >> 1;
            tx_state  <= S_DATA;
          end
          S_DATA: if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx_idx <= tx_idx + 1'b1;
            if (tx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
              o_UART_RX <= tx_par;
              tx_state  <= S_PARITY;
`else
              o_UART_RX <= 1'b1;
              tx_state  <= S_STOP;
`endif
            end else begin
              o_UART_RX <= tx_shift[0];
              tx_shift  <= tx_shift >> 1;
            end
          end
`ifdef UART_PARITY_EN
          S_PARITY: if (tx_cnt == BIT_END) begin
            tx_cnt    <= '0;
            o_UART_RX <= 1'b1;
            tx_state  <= S_STOP;
          end
`endif
          S_STOP: if (tx_cnt == BIT_END) tx_state <= S_IDLE;
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // Flags: a status read clears them one clock later; a new event wins.
  logic ovr_q, frm_q, par_q, txovf_q, irq_n_q, tx_idle;
  assign tx_idle = tx_empty && (tx_state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q   <= 1'b0;
      frm_q   <= 1'b0;
      par_q   <= 1'b0;
      txovf_q <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      if (clr_q) begin
        ovr_q   <= 1'b0;
        frm_q   <= 1'b0;
        par_q   <= 1'b0;
        txovf_q <= 1'b0;
      end
      if (ovr_set) ovr_q <= 1'b1;
      if (frm_set) frm_q <= 1'b1;
      if (par_set) par_q <= 1'b1;
      if (tx_wr && tx_full && !tx_pop) txovf_q <= 1'b1;
      irq_n_q <= ~((ctrl_q[CT_RXIE] & (~rx_empty | ovr_q | frm_q | par_q)) |
                   (ctrl_q[CT_TXIE] & tx_idle));
    end
  end

  always_comb begin
    o_uart_status            = '0;
    o_uart_status[ST_RXNE]   = (rx_count != '0);
    o_uart_status[ST_TXNF]   = (tx_count != (FW+1)'(FIFO_DEPTH));
    o_uart_status[ST_OVR]    = ovr_q;
    o_uart_status[ST_FRM]    = frm_q;
    o_uart_status[ST_TXIDLE] = tx_idle;
    o_uart_status[ST_PAR]    = par_q;
    o_uart_status[ST_TXOVF]  = txovf_q;
    o_uart_status[ST_IRQ]    = ~irq_n_q;
  end

  assign o_control = ctrl_q;
  assign o_IRQ     = irq_n_q;

endmodule
